// File: rtl/serial_fa_sequencer_if.sv
// Requester-side bundle for serial_fa_sequencer.
//   start/a/b/cin : request and operands, driven by the requester (master)
//   busy/done     : status, driven by the sequencer (slave)
//   sum/cout      : registered result, driven by the sequencer (slave)
interface serial_fa_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_fa_sequencer.sv
// serial_fa_sequencer: adds two WIDTH-bit operands LSB first by
// time-multiplexing one external combinational full-adder cell.
//   CK, RST : clock (rising edge), synchronous active-high reset
//   req     : requester bundle (start/a/b/cin in, busy/done/sum/cout out)
//   fa_a/fa_b/fa_c : current operand bits and carry to the cell
//   fa_s/fa_co     : sum and carry back from the cell
// {cout,sum} = a + b + cin, valid from the done pulse until the next
// accepted start. busy lasts WIDTH cycles; done is a one-cycle pulse.
module serial_fa_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                  CK,
  input  logic                  RST,
  serial_fa_sequencer_if.slave  req,
  output logic                  fa_a,
  output logic                  fa_b,
  output logic                  fa_c,
  input  logic                  fa_s,
  input  logic                  fa_co
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] areg, breg, sreg, sreg_shift;
  logic             carry, coreg;
  logic [CW-1:0]    cnt;
  logic             load, last_bit;
  logic             busy_o, done_o;

  // start is only honoured outside RUN
  assign load     = ((state == IDLE) || (state == DONE)) && req.start;
  assign last_bit = (state == RUN) && (cnt == LAST);

  // State register
  always_ff @(posedge CK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req.start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = req.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: cell inputs are held at zero outside RUN
  always_comb begin
    busy_o = (state == RUN);
    done_o = (state == DONE);
    fa_a   = busy_o ? areg[0] : 1'b0;
    fa_b   = busy_o ? breg[0] : 1'b0;
    fa_c   = busy_o ? carry   : 1'b0;
  end

  // Result fills from the MSB end; written as shift-then-insert so it also
  // elaborates for WIDTH=1 where sreg[WIDTH-1:1] would be an empty range.
  always_comb begin
    sreg_shift            = sreg >> 1;
    sreg_shift[WIDTH-1]   = fa_s;
  end

  // Datapath registers
  always_ff @(posedge CK) begin
    if (RST) begin
      areg  <= '0;
      breg  <= '0;
      carry <= 1'b0;
      sreg  <= '0;
      coreg <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      areg  <= req.a;
      breg  <= req.b;
      carry <= req.cin;
      sreg  <= '0;
      coreg <= 1'b0;
      cnt   <= '0;
    end else if (state == RUN) begin
      areg  <= areg >> 1;
      breg  <= breg >> 1;
      carry <= fa_co;
      sreg  <= sreg_shift;
      cnt   <= cnt + CW'(1);
      if (last_bit) coreg <= fa_co;
    end
  end

  assign req.busy = busy_o;
  assign req.done = done_o;
  assign req.sum  = sreg;
  assign req.cout = coreg;

endmodule

// File: tb/tb_serial_fa_sequencer.sv
// Bench for serial_fa_sequencer at WIDTH=8 and WIDTH=1, each wired to a
// behavioural full-adder cell. Stimulus pushes {cout,sum} = a+b+cin and the
// cycle where done must appear; per-instance monitors pop on done.
module tb_serial_fa_sequencer;

  logic CK = 1'b0;
  logic RST;
  always #5 CK = ~CK;

  int cyc = 0;
  always @(posedge CK) cyc <= cyc + 1;

  serial_fa_sequencer_if #(.WIDTH(8)) i8 ();
  serial_fa_sequencer_if #(.WIDTH(1)) i1 ();

  logic fa8_a, fa8_b, fa8_c, fa8_s, fa8_co;
  logic fa1_a, fa1_b, fa1_c, fa1_s, fa1_co;

  // External full-adder cells
  assign fa8_s  = fa8_a ^ fa8_b ^ fa8_c;
  assign fa8_co = (fa8_a & fa8_b) | (fa8_a & fa8_c) | (fa8_b & fa8_c);
  assign fa1_s  = fa1_a ^ fa1_b ^ fa1_c;
  assign fa1_co = (fa1_a & fa1_b) | (fa1_a & fa1_c) | (fa1_b & fa1_c);

  serial_fa_sequencer #(.WIDTH(8)) dut8 (
    .CK(CK), .RST(RST), .req(i8),
    .fa_a(fa8_a), .fa_b(fa8_b), .fa_c(fa8_c), .fa_s(fa8_s), .fa_co(fa8_co)
  );

  serial_fa_sequencer #(.WIDTH(1)) dut1 (
    .CK(CK), .RST(RST), .req(i1),
    .fa_a(fa1_a), .fa_b(fa1_b), .fa_c(fa1_c), .fa_s(fa1_s), .fa_co(fa1_co)
  );

  typedef struct {
    logic [8:0] res;
    int         dcyc;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic void fail_now(string nm);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endfunction

  // Monitor, WIDTH=8
  int         run8  = 0;
  bit         prev8 = 1'b0;
  logic [8:0] last8 = '0;
  always @(negedge CK) begin
    exp_t e;
    if (mon_en) begin
      if (i8.done) begin
        check("busy_len8", 64'(run8), 64'd8);
        check("busy_with_done8", 64'(i8.busy), 64'd0);
        if (q8.size() == 0) fail_now("unexpected_done8");
        else begin
          e = q8.pop_front();
          check("result8", 64'({i8.cout, i8.sum}), 64'(e.res));
          check("done_cycle8", 64'(cyc), 64'(e.dcyc));
          last8 = e.res;
        end
      end else if (!i8.busy) begin
        check("hold8", 64'({i8.cout, i8.sum}), 64'(last8));
      end
      if (i8.busy && !prev8) check("clear_on_load8", 64'({i8.cout, i8.sum}), 64'd0);
      if (!i8.busy) check("fa_idle8", 64'({fa8_a, fa8_b, fa8_c}), 64'd0);
      run8  = i8.busy ? run8 + 1 : 0;
      prev8 = i8.busy;
    end
    if (RST) last8 = '0;
  end

  // Monitor, WIDTH=1
  int         run1  = 0;
  bit         prev1 = 1'b0;
  logic [1:0] last1 = '0;
  always @(negedge CK) begin
    exp_t e;
    if (mon_en) begin
      if (i1.done) begin
        check("busy_len1", 64'(run1), 64'd1);
        if (q1.size() == 0) fail_now("unexpected_done1");
        else begin
          e = q1.pop_front();
          check("result1", 64'({i1.cout, i1.sum}), 64'(e.res));
          check("done_cycle1", 64'(cyc), 64'(e.dcyc));
          last1 = e.res[1:0];
        end
      end else if (!i1.busy) begin
        check("hold1", 64'({i1.cout, i1.sum}), 64'(last1));
      end
      if (i1.busy && !prev1) check("clear_on_load1", 64'({i1.cout, i1.sum}), 64'd0);
      if (!i1.busy) check("fa_idle1", 64'({fa1_a, fa1_b, fa1_c}), 64'd0);
      run1  = i1.busy ? run1 + 1 : 0;
      prev1 = i1.busy;
    end
    if (RST) last1 = '0;
  end

  // All stimulus runs in the phase just after a rising edge.
  task automatic wait_idle(input bit w1);
    int t = 0;
    while ((w1 ? i1.busy : i8.busy) && t < 100) begin
      @(posedge CK); #1;
      t++;
    end
    if (t >= 100) fail_now(w1 ? "wait_idle1" : "wait_idle8");
  endtask

  task automatic issue(input bit w1, input logic [7:0] a, input logic [7:0] b,
                       input logic c);
    exp_t e;
    wait_idle(w1);
    if (w1) begin
      i1.start = 1'b1; i1.a = a[0]; i1.b = b[0]; i1.cin = c;
      e.res  = 9'(a[0]) + 9'(b[0]) + 9'(c);
      e.dcyc = cyc + 1 + 1;
      q1.push_back(e);
    end else begin
      i8.start = 1'b1; i8.a = a; i8.b = b; i8.cin = c;
      e.res  = 9'(a) + 9'(b) + 9'(c);
      e.dcyc = cyc + 1 + 8;
      q8.push_back(e);
    end
    @(posedge CK); #1;
    i1.start = 1'b0;
    i8.start = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   t;
    RST = 1'b1;
    i8.start = 1'b0; i8.a = '0; i8.b = '0; i8.cin = 1'b0;
    i1.start = 1'b0; i1.a = '0; i1.b = '0; i1.cin = 1'b0;
    repeat (3) begin @(posedge CK); #1; end
    RST = 1'b0;

    // Reset state
    check("rst_busy8", 64'(i8.busy), 64'd0);
    check("rst_done8", 64'(i8.done), 64'd0);
    check("rst_sum8",  64'({i8.cout, i8.sum}), 64'd0);
    check("rst_fa8",   64'({fa8_a, fa8_b, fa8_c}), 64'd0);
    check("rst_sum1",  64'({i1.busy, i1.done, i1.cout, i1.sum}), 64'd0);
    mon_en = 1'b1;

    // Directed vectors
    issue(1'b0, 8'h5A, 8'h3C, 1'b0);
    issue(1'b0, 8'hFF, 8'h01, 1'b0);
    issue(1'b0, 8'hFF, 8'hFF, 1'b1);
    wait_idle(1'b0);
    @(posedge CK); #1;

    // start during RUN cycle 3 must be ignored
    issue(1'b0, 8'h5A, 8'h3C, 1'b0);
    repeat (2) begin @(posedge CK); #1; end
    i8.start = 1'b1; i8.a = 8'h00; i8.b = 8'h00; i8.cin = 1'b0;
    @(posedge CK); #1;
    i8.start = 1'b0;
    wait_idle(1'b0);
    @(posedge CK); #1;

    // Reset in RUN cycle 4 aborts without a done pulse
    issue(1'b0, 8'hA5, 8'h66, 1'b1);
    repeat (3) begin @(posedge CK); #1; end
    RST = 1'b1;
    if (q8.size() > 0) e = q8.pop_back();
    @(posedge CK); #1;
    RST = 1'b0;
    check("abort_busy8", 64'(i8.busy), 64'd0);
    check("abort_done8", 64'(i8.done), 64'd0);
    check("abort_sum8",  64'({i8.cout, i8.sum}), 64'd0);
    check("abort_fa8",   64'({fa8_a, fa8_b, fa8_c}), 64'd0);
    repeat (10) begin @(posedge CK); #1; end

    // start held high: reload every WIDTH+1 cycles
    i8.start = 1'b1; i8.a = 8'h01; i8.b = 8'h02; i8.cin = 1'b0;
    for (int k = 0; k < 3; k++) begin
      e.res  = 9'h003;
      e.dcyc = cyc + 1 + 9 * k + 8;
      q8.push_back(e);
    end
    repeat (19) begin @(posedge CK); #1; end
    i8.start = 1'b0;
    wait_idle(1'b0);

    // WIDTH=1 truth table
    for (int unsigned v = 0; v < 8; v++) begin
      issue(1'b1, 8'(v & 1), 8'((v >> 1) & 1), v[2]);
    end

    // Randomised traffic with occasional idle gaps
    for (int n = 0; n < 40; n++) begin
      issue(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) begin @(posedge CK); #1; end
    end
    for (int n = 0; n < 10; n++) begin
      issue(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
    end

    // Drain outstanding results
    t = 0;
    while ((q8.size() != 0 || q1.size() != 0) && t < 200) begin
      @(posedge CK); #1;
      t++;
    end
    if (t >= 200) fail_now("drain_timeout");
    repeat (3) begin @(posedge CK); #1; end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
